// File: rtl/rv32_mod_fetch_aligner.sv
// rv32_mod_fetch_aligner
// Turns a stream of naturally aligned 32-bit fetch words into one RV32IMC
// instruction per handshake, 16-bit or 32-bit. A 32-bit instruction may
// straddle two fetch words. The block tracks the PC of every emitted
// instruction and restarts on halfword-aligned redirects.
module rv32_mod_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic        out_compressed,
  output logic [31:0] out_pc
);

  // Halfword buffer. hb0_reg is always the oldest halfword, at buf_pc_reg.
  logic [15:0] hb0_reg, hb0_next;
  logic [15:0] hb1_reg, hb1_next;
  logic [1:0]  count_reg, count_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic        skip_low_reg, skip_low_next;

  logic hb0_is_32;
  logic in_fire;
  logic out_fire;

  assign hb0_is_32 = (hb0_reg[1:0] == 2'b11);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_pc         = buf_pc_reg;
  assign out_compressed = (out_instruction[1:0] != 2'b11);

  // Handshake and output selection from the buffer occupancy. in_ready never
  // depends on in_valid, so the straddle path cannot close a loop.
  always_comb begin
    out_valid       = 1'b0;
    in_ready        = 1'b0;
    out_instruction = {16'h0000, hb0_reg};
    if (!redirect_valid) begin
      case (count_reg)
        2'd0: begin
          in_ready = 1'b1;
        end
        2'd1: begin
          in_ready = out_ready;
          if (hb0_is_32) begin
            // Upper half of the instruction is the low half of the incoming word.
            out_valid       = in_valid;
            out_instruction = {in_word[15:0], hb0_reg};
          end else begin
            out_valid = 1'b1;
          end
        end
        2'd2: begin
          out_valid = 1'b1;
          if (hb0_is_32) begin
            in_ready        = out_ready;
            out_instruction = {hb1_reg, hb0_reg};
          end else begin
            // hb1 still has to be shifted down, so no room for a new word yet.
            in_ready = 1'b0;
          end
        end
        default: begin
          in_ready = 1'b0;
        end
      endcase
    end
  end

  // Next-state computation for the buffer, PC and skip flag.
  always_comb begin
    hb0_next      = hb0_reg;
    hb1_next      = hb1_reg;
    count_next    = count_reg;
    buf_pc_next   = buf_pc_reg;
    skip_low_next = skip_low_reg;
    if (redirect_valid) begin
      count_next    = 2'd0;
      buf_pc_next   = {redirect_pc[31:1], 1'b0};
      skip_low_next = redirect_pc[1];
    end else begin
      case (count_reg)
        2'd0: begin
          if (in_fire) begin
            if (skip_low_reg) begin
              // buf_pc already points at the upper halfword of this word.
              hb0_next      = in_word[31:16];
              count_next    = 2'd1;
              skip_low_next = 1'b0;
            end else begin
              hb0_next   = in_word[15:0];
              hb1_next   = in_word[31:16];
              count_next = 2'd2;
            end
          end
        end
        2'd1: begin
          if (hb0_is_32) begin
            // Straddle: both handshakes fire together, leftover upper half stays.
            if (out_fire) begin
              hb0_next    = in_word[31:16];
              buf_pc_next = buf_pc_reg + 32'd4;
            end
          end else if (out_fire) begin
            buf_pc_next = buf_pc_reg + 32'd2;
            if (in_fire) begin
              hb0_next   = in_word[15:0];
              hb1_next   = in_word[31:16];
              count_next = 2'd2;
            end else begin
              count_next = 2'd0;
            end
          end
        end
        2'd2: begin
          if (out_fire) begin
            if (hb0_is_32) begin
              buf_pc_next = buf_pc_reg + 32'd4;
              if (in_fire) begin
                hb0_next   = in_word[15:0];
                hb1_next   = in_word[31:16];
                count_next = 2'd2;
              end else begin
                count_next = 2'd0;
              end
            end else begin
              hb0_next    = hb1_reg;
              count_next  = 2'd1;
              buf_pc_next = buf_pc_reg + 32'd2;
            end
          end
        end
        default: begin
          count_next = 2'd0;
        end
      endcase
    end
  end

  // State registers; reset overrides redirect and every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb0_reg      <= 16'h0000;
      hb1_reg      <= 16'h0000;
      count_reg    <= 2'd0;
      buf_pc_reg   <= {RESET_PC[31:1], 1'b0};
      skip_low_reg <= RESET_PC[1];
    end else begin
      hb0_reg      <= hb0_next;
      hb1_reg      <= hb1_next;
      count_reg    <= count_next;
      buf_pc_reg   <= buf_pc_next;
      skip_low_reg <= skip_low_next;
    end
  end

endmodule

// File: tb/tb_rv32_mod_fetch_aligner.sv
// Directed testbench for rv32_mod_fetch_aligner. Inputs change 1 time unit
// after the rising edge; outputs are compared 2 units later, well before the
// next edge.
module tb_rv32_mod_fetch_aligner;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic        out_compressed;
  logic [31:0] out_pc;

  int checks;
  int failures;

  rv32_mod_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_word         (in_word),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_compressed  (out_compressed),
    .out_pc          (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    in_valid = 1'b0;
    in_word = 32'h0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=00000000", out_pc); end
    $display("txn reset done");
  endtask

  task automatic test_aligned();
    do_reset();
    in_valid = 1'b1; in_word = 32'h0000_0093;
    settle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL aligned_empty_valid got=%0b exp=0", out_valid); end
    tick();
    in_word = 32'h0010_8113;
    settle();
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0000_0093 || out_pc !== 32'h0 || out_compressed !== 1'b0)
      begin failures++; $display("FAIL aligned_i0 got v=%0b ins=%h pc=%h c=%0b exp v=1 ins=00000093 pc=00000000 c=0", out_valid, out_instruction, out_pc, out_compressed); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL aligned_in_ready got=%0b exp=1", in_ready); end
    $display("txn aligned ins=%h pc=%h", out_instruction, out_pc);
    tick();
    in_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0010_8113 || out_pc !== 32'h4 || out_compressed !== 1'b0)
      begin failures++; $display("FAIL aligned_i1 got v=%0b ins=%h pc=%h c=%0b exp v=1 ins=00108113 pc=00000004 c=0", out_valid, out_instruction, out_pc, out_compressed); end
    $display("txn aligned ins=%h pc=%h", out_instruction, out_pc);
    tick();
    settle();
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h8) begin failures++; $display("FAIL aligned_drain got v=%0b pc=%h exp v=0 pc=00000008", out_valid, out_pc); end
  endtask

  task automatic test_compressed_pair();
    do_reset();
    in_valid = 1'b1; in_word = 32'h4505_0505;
    tick();
    in_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0000_0505 || out_pc !== 32'h0 || out_compressed !== 1'b1)
      begin failures++; $display("FAIL cpair_c0 got v=%0b ins=%h pc=%h c=%0b exp v=1 ins=00000505 pc=00000000 c=1", out_valid, out_instruction, out_pc, out_compressed); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL cpair_in_ready got=%0b exp=0", in_ready); end
    $display("txn cpair ins=%h pc=%h", out_instruction, out_pc);
    tick();
    settle();
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0000_4505 || out_pc !== 32'h2 || out_compressed !== 1'b1)
      begin failures++; $display("FAIL cpair_c1 got v=%0b ins=%h pc=%h c=%0b exp v=1 ins=00004505 pc=00000002 c=1", out_valid, out_instruction, out_pc, out_compressed); end
    $display("txn cpair ins=%h pc=%h", out_instruction, out_pc);
    tick();
    settle();
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h4) begin failures++; $display("FAIL cpair_drain got v=%0b pc=%h exp v=0 pc=00000004", out_valid, out_pc); end
  endtask

  task automatic test_straddle();
    do_reset();
    in_valid = 1'b1; in_word = 32'h0093_0505;
    tick();
    in_valid = 1'b0;
    settle();
    checks++; if (out_instruction !== 32'h0000_0505 || out_pc !== 32'h0) begin failures++; $display("FAIL strad_c0 got ins=%h pc=%h exp ins=00000505 pc=00000000", out_instruction, out_pc); end
    tick();
    settle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL strad_wait_valid got=%0b exp=0", out_valid); end
    in_valid = 1'b1; in_word = 32'h1234_0000;
    settle();
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0000_0093 || out_pc !== 32'h2 || out_compressed !== 1'b0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL strad_i32 got v=%0b ins=%h pc=%h c=%0b rdy=%0b exp v=1 ins=00000093 pc=00000002 c=0 rdy=1", out_valid, out_instruction, out_pc, out_compressed, in_ready); end
    $display("txn straddle ins=%h pc=%h", out_instruction, out_pc);
    tick();
    in_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0000_1234 || out_pc !== 32'h6 || out_compressed !== 1'b1)
      begin failures++; $display("FAIL strad_rest got v=%0b ins=%h pc=%h c=%0b exp v=1 ins=00001234 pc=00000006 c=1", out_valid, out_instruction, out_pc, out_compressed); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1; in_word = 32'h0093_0505;
    tick();
    settle();
    checks++; if (in_ready !== 1'b0 || out_instruction !== 32'h0000_0505) begin failures++; $display("FAIL b2b_c0 got rdy=%0b ins=%h exp rdy=0 ins=00000505", in_ready, out_instruction); end
    tick();
    in_word = 32'h0113_00AA;
    settle();
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h00AA_0093 || out_pc !== 32'h2) begin failures++; $display("FAIL b2b_s0 got v=%0b ins=%h pc=%h exp v=1 ins=00aa0093 pc=00000002", out_valid, out_instruction, out_pc); end
    $display("txn b2b ins=%h pc=%h", out_instruction, out_pc);
    tick();
    in_word = 32'h0193_00BB;
    settle();
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h00BB_0113 || out_pc !== 32'h6) begin failures++; $display("FAIL b2b_s1 got v=%0b ins=%h pc=%h exp v=1 ins=00bb0113 pc=00000006", out_valid, out_instruction, out_pc); end
    $display("txn b2b ins=%h pc=%h", out_instruction, out_pc);
    tick();
    in_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'hA) begin failures++; $display("FAIL b2b_tail got v=%0b pc=%h exp v=0 pc=0000000a", out_valid, out_pc); end
  endtask

  task automatic test_redirect_halfword();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    settle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL redir_cycle got v=%0b rdy=%0b exp v=0 rdy=0", out_valid, in_ready); end
    tick();
    redirect_valid = 1'b0;
    in_valid = 1'b1; in_word = 32'h4505_AAAA;
    tick();
    in_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0000_4505 || out_pc !== 32'h102 || out_compressed !== 1'b1)
      begin failures++; $display("FAIL redir_out got v=%0b ins=%h pc=%h c=%0b exp v=1 ins=00004505 pc=00000102 c=1", out_valid, out_instruction, out_pc, out_compressed); end
    $display("txn redirect ins=%h pc=%h", out_instruction, out_pc);
    tick();
    settle();
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h104) begin failures++; $display("FAIL redir_drain got v=%0b pc=%h exp v=0 pc=00000104", out_valid, out_pc); end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    in_valid = 1'b1; in_word = 32'h4505_0505;
    tick();
    out_ready = 1'b0;
    in_word = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0000_0505 || out_pc !== 32'h0 || in_ready !== 1'b0)
        begin failures++; $display("FAIL stall_%0d got v=%0b ins=%h pc=%h rdy=%0b exp v=1 ins=00000505 pc=00000000 rdy=0", i, out_valid, out_instruction, out_pc, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    settle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL stall_redir got v=%0b rdy=%0b exp v=0 rdy=0", out_valid, in_ready); end
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    settle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL stall_cleared got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready); end
    in_valid = 1'b1; in_word = 32'h0000_0013;
    tick();
    in_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0000_0013 || out_pc !== 32'h200 || out_compressed !== 1'b0)
      begin failures++; $display("FAIL stall_next got v=%0b ins=%h pc=%h c=%0b exp v=1 ins=00000013 pc=00000200 c=0", out_valid, out_instruction, out_pc, out_compressed); end
    $display("txn stall ins=%h pc=%h", out_instruction, out_pc);
    tick();
  endtask

  task automatic test_wrap_zero();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    in_valid = 1'b1; in_word = 32'h0000_0000;
    tick();
    in_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0 || out_pc !== 32'hFFFF_FFFE || out_compressed !== 1'b1)
      begin failures++; $display("FAIL wrap_out got v=%0b ins=%h pc=%h c=%0b exp v=1 ins=00000000 pc=fffffffe c=1", out_valid, out_instruction, out_pc, out_compressed); end
    $display("txn wrap ins=%h pc=%h", out_instruction, out_pc);
    tick();
    settle();
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got v=%0b pc=%h exp v=0 pc=00000000", out_valid, out_pc); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    in_valid = 1'b1; in_word = 32'h4505_0505;
    tick();
    in_valid = 1'b0;
    tick();
    // count is 1 here; reset and redirect together, reset must win.
    rst = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    rst = 1'b0;
    redirect_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL rstmid_state got v=%0b rdy=%0b pc=%h exp v=0 rdy=1 pc=00000000", out_valid, in_ready, out_pc); end
    in_valid = 1'b1; in_word = 32'h0000_0093;
    tick();
    in_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0000_0093 || out_pc !== 32'h0)
      begin failures++; $display("FAIL rstmid_first got v=%0b ins=%h pc=%h exp v=1 ins=00000093 pc=00000000", out_valid, out_instruction, out_pc); end
    $display("txn rstmid ins=%h pc=%h", out_instruction, out_pc);
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_aligned();
    test_compressed_pair();
    test_straddle();
    test_back_to_back();
    test_redirect_halfword();
    test_stall_redirect();
    test_wrap_zero();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
